// File: rtl/sub12_pkg.sv
// Shared definitions for the modulo-N down-counting timer.
// Holds the FSM state encoding and the default modulus/width.
// Imported by sub12_next and sub12_timer.
package sub12_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int MODN_DEF = 12;
    localparam int W_DEF    = 4;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN,
        S_DONE = ST_DONE
    } state_t;

endpackage

// File: rtl/sub12_next.sv
// Purpose: combinational decrement-with-wrap for the modulo-N timer (cs -> ns).
// Latency: purely combinational, zero cycles.
// Backpressure: none; output always reflects the present count.
// Ports: cs (present count, W bits) in, ns (next count, W bits) out.
module sub12_next
    import sub12_pkg::*;
#(
    parameter int MODN = MODN_DEF,
    parameter int W    = W_DEF
) (
    input  logic [W-1:0] cs,
    output logic [W-1:0] ns
);

    localparam logic [W-1:0] MAXV   = W'(MODN - 1);
    localparam logic [W:0]   MODN_X = (W + 1)'(MODN);

    // Zero wraps to the top value; an out-of-range count (never reached in
    // normal operation) is pulled back to the top value as well.
    always_comb begin
        ns = MAXV;
        if ((cs != '0) && ({1'b0, cs} < MODN_X)) begin
            ns = cs - 1'b1;
        end
    end

endmodule

// File: rtl/sub12_timer.sv
// Purpose: modulo-N down-counting timer with IDLE/RUN/DONE control and a one-cycle borrow pulse.
// Latency: start -> busy after 1 clock; borrow N+1 enabled cycles after RUN is entered from load N.
// Backpressure: en (active-low) stalls the count in RUN; ld overrides everything except reset.
// Ports: clk, rst_n (async active-low), en (active-low count enable), ld, din[W], start;
//        outputs cs[W], borrow, busy, done - all registered.
// Option: define SUB12_AUTORELOAD_EN to reload MODN-1 at terminal count and keep running.
module sub12_timer
    import sub12_pkg::*;
#(
    parameter int MODN = MODN_DEF,
    parameter int W    = W_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         ld,
    input  logic [W-1:0] din,
    input  logic         start,
    output logic [W-1:0] cs,
    output logic         borrow,
    output logic         busy,
    output logic         done
);

    localparam logic [W-1:0] MAXV   = W'(MODN - 1);
    localparam logic [W:0]   MODN_X = (W + 1)'(MODN);

    state_t       state;
    logic [W-1:0] ns;
    logic [W-1:0] ld_val;
    logic         cs_zero;

    sub12_next #(
        .MODN (MODN),
        .W    (W)
    ) u_next (
        .cs (cs),
        .ns (ns)
    );

    // Load values beyond the modulus saturate to the top count.
    assign ld_val  = ({1'b0, din} >= MODN_X) ? MAXV : din;
    assign cs_zero = (cs == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            cs     <= '0;
            borrow <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else if (ld) begin
            cs     <= ld_val;
            state  <= S_IDLE;
            borrow <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            borrow <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
`ifdef SUB12_AUTORELOAD_EN
                        // A zero start value simply borrows on the first
                        // enabled cycle and reloads, so always run.
                        state <= S_RUN;
                        busy  <= 1'b1;
`else
                        if (!cs_zero) begin
                            state <= S_RUN;
                            busy  <= 1'b1;
                        end else begin
                            state  <= S_DONE;
                            done   <= 1'b1;
                            borrow <= 1'b1;
                        end
`endif
                    end
                end
                S_RUN: begin
                    if (!en) begin
                        if (cs_zero) begin
                            borrow <= 1'b1;
`ifdef SUB12_AUTORELOAD_EN
                            cs     <= ns;   // ns is MAXV when cs is zero
`else
                            state  <= S_DONE;
                            busy   <= 1'b0;
                            done   <= 1'b1;
`endif
                        end else begin
                            cs <= ns;
                        end
                    end
                end
                S_DONE: begin
                    // Count stays parked at zero; a start re-signals the
                    // terminal event but only a load leaves this state.
                    if (start) begin
                        borrow <= 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sub12_timer.sv
module tb_sub12_timer;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       ld;
    logic [3:0] din;
    logic       start;
    logic [3:0] cs;
    logic       borrow;
    logic       busy;
    logic       done;

    int n_tests;
    int n_fail;

    sub12_timer dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .ld     (ld),
        .din    (din),
        .start  (start),
        .cs     (cs),
        .borrow (borrow),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [3:0] v);
        ld = 1'b1; din = v; start = 1'b0;
        step();
        ld = 1'b0;
    endtask

    task automatic kick();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n = 1'b0; en = 1'b1; ld = 1'b0; din = '0; start = 1'b0;
        #12;
        // Reset state
        chk("rst_cs", 32'(cs), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_borrow", 32'(borrow), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Async reset mid-RUN with cs=7
        load(4'd9);
        kick();
        chk("t1_busy_run", 32'(busy), 1);
        en = 1'b0;
        step();
        step();
        en = 1'b1;
        chk("t1_cs7", 32'(cs), 7);
        #2 rst_n = 1'b0;
        #1;
        chk("t1_async_cs", 32'(cs), 0);
        chk("t1_async_busy", 32'(busy), 0);
        chk("t1_async_done", 32'(done), 0);
        chk("t1_async_borrow", 32'(borrow), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("t1_after_rst_busy", 32'(busy), 0);

`ifndef SUB12_AUTORELOAD_EN
        // Load 5, run with en held low
        load(4'd5);
        chk("t2_ld_cs", 32'(cs), 5);
        chk("t2_ld_busy", 32'(busy), 0);
        en = 1'b0;
        kick();
        chk("t2_start_busy", 32'(busy), 1);
        chk("t2_start_cs", 32'(cs), 5);
        for (int k = 4; k >= 0; k--) begin
            step();
            chk($sformatf("t2_cs_%0d", k), 32'(cs), 32'(k));
            chk($sformatf("t2_noborrow_%0d", k), 32'(borrow), 0);
        end
        step();
        chk("t2_borrow", 32'(borrow), 1);
        chk("t2_done", 32'(done), 1);
        chk("t2_busy_off", 32'(busy), 0);
        chk("t2_cs_zero", 32'(cs), 0);
        step();
        chk("t2_borrow_once", 32'(borrow), 0);
        chk("t2_done_hold", 32'(done), 1);
        chk("t2_cs_hold", 32'(cs), 0);
        en = 1'b1;
`endif

        // Load 9, en toggling: count moves only on enabled cycles
        begin
            int exp_cs;
            int n_en;
            int seen_at;
            load(4'd9);
            kick();
            exp_cs  = 9;
            n_en    = 0;
            seen_at = -1;
            for (int c = 0; c < 40 && seen_at < 0; c++) begin
                en = (c % 2 == 0) ? 1'b0 : 1'b1;
                step();
                if (en == 1'b0) begin
                    n_en++;
                    if (exp_cs > 0) exp_cs--;
                end
                chk($sformatf("t3_cs_c%0d", c), 32'(cs), 32'(exp_cs));
                if (borrow) seen_at = n_en;
            end
            en = 1'b1;
            chk("t3_borrow_after_10", 32'(seen_at), 10);
`ifndef SUB12_AUTORELOAD_EN
            chk("t3_done", 32'(done), 1);
`endif
        end

        // Saturating load and ld+start collision
        load(4'd14);
        chk("t4_sat_cs", 32'(cs), 11);
        ld = 1'b1; din = 4'd3; start = 1'b1;
        step();
        ld = 1'b0; start = 1'b0;
        chk("t4_ldstart_cs", 32'(cs), 3);
        chk("t4_ldstart_busy", 32'(busy), 0);
        chk("t4_ldstart_done", 32'(done), 0);
        step();
        chk("t4_idle_hold_busy", 32'(busy), 0);
        chk("t4_idle_hold_cs", 32'(cs), 3);

`ifndef SUB12_AUTORELOAD_EN
        // Start from IDLE with cs=0
        load(4'd0);
        kick();
        chk("t6_done", 32'(done), 1);
        chk("t6_borrow", 32'(borrow), 1);
        chk("t6_busy", 32'(busy), 0);
        chk("t6_cs", 32'(cs), 0);
        step();
        chk("t6_borrow_once", 32'(borrow), 0);
        chk("t6_done_hold", 32'(done), 1);
`else
        // Auto-reload: load 0, run 30 enabled cycles
        load(4'd0);
        kick();
        chk("t5_busy_start", 32'(busy), 1);
        en = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            step();
            chk($sformatf("t5_cs_%0d", k), 32'(cs), 32'((12 - (k % 12)) % 12));
            chk($sformatf("t5_borrow_%0d", k), 32'(borrow), 32'((k % 12) == 1));
            chk($sformatf("t5_busy_%0d", k), 32'(busy), 1);
            chk($sformatf("t5_done_%0d", k), 32'(done), 0);
        end
        en = 1'b1;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
